// File: rtl/hilo_muldiv_sequencer.sv
// hilo_muldiv_sequencer
// Multi-cycle multiply/divide sequencer feeding the Hi/Lo register unit.
// Computes a 64-bit product (shift-add) or quotient/remainder (restoring
// divide) one bit per cycle, applies sign correction, then drives the Hi/Lo
// write strobes for exactly one COMMIT cycle.
//
// Optional build macro: HILO_EARLY_TERM_EN
//   defined   : multiply CALC exits as soon as the remaining multiplier bits
//               are all zero (minimum one CALC cycle).
//   undefined : every multiply spends a fixed 32 CALC cycles.
module hilo_muldiv_sequencer #(
  parameter logic [31:0] DIV_BY_ZERO_LO = 32'hFFFF_FFFF,
  parameter int          OP_W           = 3
) (
  input  logic            Clk,
  input  logic            Reset,
  input  logic            Start,
  input  logic [OP_W-1:0] Op,
  input  logic [31:0]     RsData,
  input  logic [31:0]     RtData,
  input  logic            ReadHiLo,
  output logic            Busy,
  output logic            Stall,
  output logic            Done,
  output logic [31:0]     Upper,
  output logic [31:0]     Lower,
  output logic            HiLoALUControl,
  output logic            AddToHi,
  output logic            AddToLo,
  output logic            MoveToHi,
  output logic            MoveToLo
);

  localparam logic [OP_W-1:0] OP_MULT  = OP_W'(0);
  localparam logic [OP_W-1:0] OP_MULTU = OP_W'(1);
  localparam logic [OP_W-1:0] OP_DIV   = OP_W'(2);
  localparam logic [OP_W-1:0] OP_DIVU  = OP_W'(3);
  localparam logic [OP_W-1:0] OP_MADD  = OP_W'(4);
  localparam logic [OP_W-1:0] OP_MSUB  = OP_W'(5);
  localparam logic [OP_W-1:0] OP_MTHI  = OP_W'(6);
  localparam logic [OP_W-1:0] OP_MTLO  = OP_W'(7);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CALC   = 2'd1,
    FIXUP  = 2'd2,
    COMMIT = 2'd3
  } state_e;

  state_e            state_q, state_d;
  logic [OP_W-1:0]   op_q, op_d;
  logic [63:0]       mcand_q, mcand_d;   // multiplicand, shifted left each CALC cycle
  logic [31:0]       opb_q, opb_d;       // multiplier (shifted right) or divisor
  logic [63:0]       acc_q, acc_d;       // product, or {remainder, quotient}
  logic [5:0]        cnt_q, cnt_d;
  logic              neg_res_q, neg_res_d;
  logic              neg_rem_q, neg_rem_d;
  logic              dbz_q, dbz_d;
  logic [31:0]       rs_q, rs_d;         // raw dividend, committed to HI on divide by zero
  logic [31:0]       upper_q, upper_d;
  logic [31:0]       lower_q, lower_d;

  // Operand decode for the op being presented this cycle
  logic        in_signed;
  logic        in_mul;
  logic        in_move;
  logic [31:0] abs_rs;
  logic [31:0] abs_rt;

  // Datapath step results for the latched op
  logic        op_is_mul;
  logic [63:0] acc_mul;
  logic [32:0] rem_sh;
  logic        div_ge;
  logic [31:0] rem_new;
  logic [63:0] acc_div;
  logic        calc_last;
  logic [63:0] prod_fix;
  logic [31:0] res_hi;
  logic [31:0] res_lo;

  // Decode and absolute values of the incoming operands
  always_comb begin
    in_signed = (Op == OP_MULT) || (Op == OP_DIV) || (Op == OP_MADD) || (Op == OP_MSUB);
    in_mul    = (Op == OP_MULT) || (Op == OP_MULTU) || (Op == OP_MADD) || (Op == OP_MSUB);
    in_move   = (Op == OP_MTHI) || (Op == OP_MTLO);
    abs_rs    = (in_signed && RsData[31]) ? (32'd0 - RsData) : RsData;
    abs_rt    = (in_signed && RtData[31]) ? (32'd0 - RtData) : RtData;
  end

  // One CALC iteration of each algorithm plus the sign-corrected result
  always_comb begin
    op_is_mul = (op_q == OP_MULT) || (op_q == OP_MULTU) ||
                (op_q == OP_MADD) || (op_q == OP_MSUB);

    // Shift-add: add the aligned multiplicand when the current multiplier bit is set
    acc_mul = opb_q[0] ? (acc_q + mcand_q) : acc_q;

    // Restoring divide: shift the next dividend bit into the partial remainder.
    // When the subtraction succeeds the true remainder fits in 32 bits, so a
    // 32-bit modular subtract yields the exact value.
    rem_sh  = acc_q[63:31];
    div_ge  = (rem_sh >= {1'b0, opb_q});
    rem_new = rem_sh[31:0] - (div_ge ? opb_q : 32'd0);
    acc_div = {rem_new, acc_q[30:0], div_ge};

`ifdef HILO_EARLY_TERM_EN
    // Stop once no set multiplier bits remain after this iteration
    calc_last = (cnt_q == 6'd31) || (op_is_mul && (opb_q[31:1] == 31'd0));
`else
    calc_last = (cnt_q == 6'd31);
`endif

    prod_fix = neg_res_q ? (64'd0 - acc_q) : acc_q;
    if (op_is_mul) begin
      res_hi = prod_fix[63:32];
      res_lo = prod_fix[31:0];
    end else if (dbz_q) begin
      res_hi = rs_q;
      res_lo = DIV_BY_ZERO_LO;
    end else begin
      res_hi = neg_rem_q ? (32'd0 - acc_q[63:32]) : acc_q[63:32];
      res_lo = neg_res_q ? (32'd0 - acc_q[31:0])  : acc_q[31:0];
    end
  end

  // Next-state and datapath register updates
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    state_d   = state_q;
    op_d      = op_q;
    mcand_d   = mcand_q;
    opb_d     = opb_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    neg_res_d = neg_res_q;
    neg_rem_d = neg_rem_q;
    dbz_d     = dbz_q;
    rs_d      = rs_q;
    upper_d   = upper_q;
    lower_d   = lower_q;

    unique case (state_q)
      IDLE: begin
        if (Start) begin
          op_d      = Op;
          rs_d      = RsData;
          cnt_d     = 6'd0;
          neg_res_d = in_signed && (RsData[31] ^ RtData[31]);
          neg_rem_d = in_signed && RsData[31];
          dbz_d     = !in_mul && !in_move && (RtData == 32'd0);
          opb_d     = abs_rt;
          if (in_mul) begin
            mcand_d = {32'd0, abs_rs};
            acc_d   = 64'd0;
          end else begin
            mcand_d = 64'd0;
            acc_d   = {32'd0, abs_rs};
          end
          if (Op == OP_MTHI) upper_d = RsData;
          if (Op == OP_MTLO) lower_d = RsData;
          state_d = in_move ? COMMIT : CALC;
        end
      end
      CALC: begin
        cnt_d = cnt_q + 6'd1;
        if (op_is_mul) begin
          acc_d   = acc_mul;
          mcand_d = {mcand_q[62:0], 1'b0};
          opb_d   = {1'b0, opb_q[31:1]};
        end else begin
          acc_d = acc_div;
        end
        if (calc_last) state_d = FIXUP;
      end
      FIXUP: begin
        upper_d = res_hi;
        lower_d = res_lo;
        state_d = COMMIT;
      end
      COMMIT: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset abandons any operation in flight
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q   <= IDLE;
      op_q      <= '0;
      mcand_q   <= '0;
      opb_q     <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      dbz_q     <= 1'b0;
      rs_q      <= '0;
      upper_q   <= '0;
      lower_q   <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the values
      // from before this edge, independent of statement order.
      state_q   <= state_d;
      op_q      <= op_d;
      mcand_q   <= mcand_d;
      opb_q     <= opb_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      neg_res_q <= neg_res_d;
      neg_rem_q <= neg_rem_d;
      dbz_q     <= dbz_d;
      rs_q      <= rs_d;
      upper_q   <= upper_d;
      lower_q   <= lower_d;
    end
  end

  // Status and Hi/Lo strobes; strobes fire only in COMMIT
  always_comb begin
    Busy           = (state_q != IDLE);
    Stall          = Busy && (Start || ReadHiLo);
    Done           = (state_q == COMMIT);
    Upper          = upper_q;
    Lower          = lower_q;
    HiLoALUControl = 1'b0;
    AddToHi        = 1'b0;
    AddToLo        = 1'b0;
    MoveToHi       = 1'b0;
    MoveToLo       = 1'b0;
    if (state_q == COMMIT) begin
      unique case (op_q)
        OP_MADD: begin
          AddToHi = 1'b1;
          AddToLo = 1'b1;
        end
        OP_MSUB: begin
          AddToHi        = 1'b1;
          AddToLo        = 1'b1;
          HiLoALUControl = 1'b1;
        end
        OP_MTHI: MoveToHi = 1'b1;
        OP_MTLO: MoveToLo = 1'b1;
        default: begin
          MoveToHi = 1'b1;
          MoveToLo = 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_hilo_muldiv_sequencer.sv
// tb_hilo_muldiv_sequencer
// Directed bench: each operation pushes its model result into a scoreboard
// queue when driven; the entry is popped and compared when Done is seen.
module tb_hilo_muldiv_sequencer;

  localparam logic [31:0] DBZ_LO = 32'hFFFF_FFFF;

  logic        Clk;
  logic        Reset;
  logic        Start;
  logic [2:0]  Op;
  logic [31:0] RsData;
  logic [31:0] RtData;
  logic        ReadHiLo;
  logic        Busy;
  logic        Stall;
  logic        Done;
  logic [31:0] Upper;
  logic [31:0] Lower;
  logic        HiLoALUControl;
  logic        AddToHi;
  logic        AddToLo;
  logic        MoveToHi;
  logic        MoveToLo;

  typedef struct {
    string       tag;
    logic [31:0] up;
    logic [31:0] lo;
    logic [4:0]  strb;   // {MoveToHi, MoveToLo, AddToHi, AddToLo, HiLoALUControl}
    int          lat;
  } exp_t;

  exp_t        sb_q[$];
  int          checks = 0;
  int          errors = 0;
  logic [31:0] model_up = 32'd0;
  logic [31:0] model_lo = 32'd0;

  hilo_muldiv_sequencer #(.DIV_BY_ZERO_LO(DBZ_LO), .OP_W(3)) dut (
    .Clk(Clk), .Reset(Reset), .Start(Start), .Op(Op), .RsData(RsData),
    .RtData(RtData), .ReadHiLo(ReadHiLo), .Busy(Busy), .Stall(Stall),
    .Done(Done), .Upper(Upper), .Lower(Lower), .HiLoALUControl(HiLoALUControl),
    .AddToHi(AddToHi), .AddToLo(AddToLo), .MoveToHi(MoveToHi), .MoveToLo(MoveToLo)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  function automatic logic [4:0] strobes();
    return {MoveToHi, MoveToLo, AddToHi, AddToLo, HiLoALUControl};
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference result for one op, computed with native wide arithmetic
  task automatic model(input logic [2:0] op, input logic [31:0] rs, input logic [31:0] rt,
                       output exp_t e);
    longint      sp;
    logic [63:0] p;
    logic [63:0] q;
    logic [63:0] r;
    int          bits;
    logic [31:0] m;
    sp     = longint'($signed(rs)) * longint'($signed(rt));
    e.up   = model_up;
    e.lo   = model_lo;
    e.strb = 5'b11000;
    e.lat  = 34;
    case (op)
      3'd0, 3'd4, 3'd5: begin
        p    = 64'(sp);
        e.up = p[63:32];
        e.lo = p[31:0];
        if (op == 3'd4) e.strb = 5'b00110;
        if (op == 3'd5) e.strb = 5'b00111;
      end
      3'd1: begin
        p    = {32'd0, rs} * {32'd0, rt};
        e.up = p[63:32];
        e.lo = p[31:0];
      end
      3'd2: begin
        if (rt == 32'd0) begin
          e.up = rs;
          e.lo = DBZ_LO;
        end else begin
          q    = 64'(longint'($signed(rs)) / longint'($signed(rt)));
          r    = 64'(longint'($signed(rs)) % longint'($signed(rt)));
          e.up = r[31:0];
          e.lo = q[31:0];
        end
      end
      3'd3: begin
        if (rt == 32'd0) begin
          e.up = rs;
          e.lo = DBZ_LO;
        end else begin
          e.up = rs % rt;
          e.lo = rs / rt;
        end
      end
      3'd6: begin
        e.up   = rs;
        e.strb = 5'b10000;
        e.lat  = 1;
      end
      default: begin
        e.lo   = rs;
        e.strb = 5'b01000;
        e.lat  = 1;
      end
    endcase
`ifdef HILO_EARLY_TERM_EN
    if (op == 3'd0 || op == 3'd1 || op == 3'd4 || op == 3'd5) begin
      m    = (op != 3'd1 && rt[31]) ? (32'd0 - rt) : rt;
      bits = 1;
      for (int i = 0; i < 32; i++) if (m[i]) bits = i + 1;
      e.lat = bits + 2;
    end
`else
    m    = 32'd0;
    bits = 0;
`endif
    model_up = e.up;
    model_lo = e.lo;
  endtask

  // Drive one op; optionally re-present Start/ReadHiLo while busy at cycle poke_cyc
  task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] rs,
                        input logic [31:0] rt, input logic rd, input int poke_cyc);
    exp_t e;
    exp_t got;
    int   cyc;
    bit   done_seen;
    bit   busy_ok;
    bit   strb_ok;
    model(op, rs, rt, e);
    e.tag = tag;
    sb_q.push_back(e);
    @(negedge Clk);
    Start = 1'b1; Op = op; RsData = rs; RtData = rt; ReadHiLo = rd;
    #1 check({tag, "_stall_idle"}, 64'(Stall), 64'd0);
    cyc = 0; done_seen = 0; busy_ok = 1; strb_ok = 1;
    while (!done_seen && cyc < 60) begin
      @(negedge Clk);
      cyc++;
      if (!Busy) busy_ok = 0;
      if (!Done && strobes() != 5'd0) strb_ok = 0;
      if (Done) begin
        done_seen = 1;
        got = sb_q.pop_front();
        check({got.tag, "_latency"}, 64'(cyc), 64'(got.lat));
        check({got.tag, "_upper"}, 64'(Upper), 64'(got.up));
        check({got.tag, "_lower"}, 64'(Lower), 64'(got.lo));
        check({got.tag, "_strobes"}, 64'(strobes()), 64'(got.strb));
      end
      if (cyc == 1 || cyc == poke_cyc + 1) begin
        Start = 1'b0; ReadHiLo = 1'b0;
      end
      if (cyc == poke_cyc) begin
        Start = 1'b1; ReadHiLo = 1'b1; Op = 3'd6; RsData = 32'hDEAD_BEEF; RtData = 32'd0;
        #1 check({tag, "_stall_busy"}, 64'(Stall), 64'd1);
      end
    end
    if (!done_seen) begin
      check({tag, "_timeout"}, 64'(cyc), 64'(e.lat));
      void'(sb_q.pop_front());
    end
    check({tag, "_busy_span"}, 64'(busy_ok), 64'd1);
    check({tag, "_strobes_quiet"}, 64'(strb_ok), 64'd1);
    @(negedge Clk);
    Start = 1'b0; ReadHiLo = 1'b0;
    check({tag, "_idle_after"}, 64'({Busy, Done}), 64'd0);
  endtask

  initial begin
    bit quiet_ok;
    Reset = 1'b1; Start = 1'b0; Op = 3'd0; RsData = 32'd0; RtData = 32'd0; ReadHiLo = 1'b0;
    repeat (2) @(negedge Clk);
    check("rst_busy", 64'(Busy), 64'd0);
    check("rst_done", 64'(Done), 64'd0);
    check("rst_upper", 64'(Upper), 64'd0);
    check("rst_lower", 64'(Lower), 64'd0);
    check("rst_strobes", 64'(strobes()), 64'd0);
    Reset = 1'b0;

    run_op("multu_max", 3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 5);
    run_op("div_neg7_2", 3'd2, 32'hFFFF_FFF9, 32'd2, 1'b0, 0);
    run_op("divu_big", 3'd3, 32'h8000_0000, 32'h10, 1'b0, 0);
    run_op("div_by_zero", 3'd2, 32'd5, 32'd0, 1'b0, 0);
    run_op("divu_by_zero", 3'd3, 32'd9, 32'd0, 1'b0, 0);
    run_op("div_overflow", 3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 0);
    run_op("div_7_neg2", 3'd2, 32'd7, 32'hFFFF_FFFE, 1'b0, 0);
    run_op("mult_neg3_5", 3'd0, 32'hFFFF_FFFD, 32'd5, 1'b0, 0);
    run_op("msub_3_4", 3'd5, 32'd3, 32'd4, 1'b0, 0);
    run_op("madd_neg1_1", 3'd4, 32'hFFFF_FFFF, 32'd1, 1'b0, 0);
    run_op("mthi", 3'd6, 32'h0000_CAFE, 32'd0, 1'b0, 0);
    run_op("mtlo_stall", 3'd7, 32'h0000_1234, 32'd0, 1'b0, 1);

    // Reset in the middle of a divide: no commit, no strobes, outputs cleared
    quiet_ok = 1;
    @(negedge Clk);
    Start = 1'b1; Op = 3'd2; RsData = 32'hFFFF_FFF9; RtData = 32'd2;
    for (int c = 1; c <= 10; c++) begin
      @(negedge Clk);
      Start = 1'b0;
      if (strobes() != 5'd0 || Done) quiet_ok = 0;
    end
    check("rst_mid_busy_before", 64'(Busy), 64'd1);
    Reset = 1'b1;
    #1 check("rst_mid_busy", 64'(Busy), 64'd0);
    @(negedge Clk);
    Reset = 1'b0;
    model_up = 32'd0;
    model_lo = 32'd0;
    for (int c = 0; c < 40; c++) begin
      @(negedge Clk);
      if (strobes() != 5'd0 || Done || Busy) quiet_ok = 0;
    end
    check("rst_mid_quiet", 64'(quiet_ok), 64'd1);
    check("rst_mid_outputs", {Upper, Lower}, 64'd0);

    run_op("div_after_rst", 3'd2, 32'hFFFF_FFF9, 32'd2, 1'b0, 0);
    check("sb_empty", 64'(sb_q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

endmodule
